shift_feed_ctrl: RTL

SHIFT_FEED_CTRL -- requirements
Module: shift_feed_ctrl

---
 rtl/shift_feed_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/shift_feed_ctrl.sv
// Shift-register feed controller: queues {data, count} words in a 4-deep FIFO and
// drives each word with 1 + count enable cycles. Optional SHIFT_FEED_CNT_EN adds sent_cnt.
module shift_feed_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [3:0] s_data,
   input  logic [2:0] s_count,
   output logic [3:0] out_data,
   output logic       out_ex,
   output logic       busy,
`ifdef SHIFT_FEED_CNT_EN
   output logic [7:0] sent_cnt,
`endif
   output logic [2:0] fifo_count
);

   // state | meaning
   // IDLE  | no word in flight, out_ex low
   // LOAD  | first enable cycle of a freshly popped word
   // SHIFT | additional enable cycles while remaining counts down
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t     state_q;
   state_t     state_nxt;
   logic [2:0] remaining;
   logic [2:0] rem_nxt;
   logic [3:0] out_data_nxt;
   logic       out_ex_nxt;
   logic       pop;
   logic       push;

   logic [3:0] fifo_data [4];
   logic [2:0] fifo_cnt  [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [3:0] head_data;
   logic [2:0] head_cnt;
   logic       fifo_empty;

   assign s_ready    = (fifo_count != 3'd4);
   assign push       = s_valid && s_ready;
   assign fifo_empty = (fifo_count == 3'd0);
   assign head_data  = fifo_data[rd_ptr];
   assign head_cnt   = fifo_cnt[rd_ptr];
   assign busy       = (state_q != IDLE);

   // Storage needs no reset: entries are only read once fifo_count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= s_data;
         fifo_cnt[wr_ptr]  <= s_count;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         fifo_count <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 3'd1;
            2'b01:   fifo_count <= fifo_count - 3'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         remaining <= 3'd0;
         out_data  <= 4'd0;
         out_ex    <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         remaining <= rem_nxt;
         out_data  <= out_data_nxt;
         out_ex    <= out_ex_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      rem_nxt      = remaining;
      out_data_nxt = out_data;
      out_ex_nxt   = out_ex;
      pop          = 1'b0;
      case (state_q)
         IDLE: begin
            out_ex_nxt = 1'b0;
            if (!fifo_empty) begin
               pop          = 1'b1;
               state_nxt    = LOAD;
               out_data_nxt = head_data;
               out_ex_nxt   = 1'b1;
               rem_nxt      = head_cnt;
            end
         end
         LOAD, SHIFT: begin
            if (remaining != 3'd0) begin
               state_nxt  = SHIFT;
               out_ex_nxt = 1'b1;
               rem_nxt    = remaining - 3'd1;
            end else if (!fifo_empty) begin
               // Chain straight into the next word so the enable never drops.
               pop          = 1'b1;
               state_nxt    = LOAD;
               out_data_nxt = head_data;
               out_ex_nxt   = 1'b1;
               rem_nxt      = head_cnt;
            end else begin
               state_nxt  = IDLE;
               out_ex_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt  = IDLE;
            out_ex_nxt = 1'b0;
            rem_nxt    = 3'd0;
         end
      endcase
   end

`ifdef SHIFT_FEED_CNT_EN
   logic word_done;

   // A word's last enable cycle is the one where nothing remains to count down.
   assign word_done = (state_q != IDLE) && (remaining == 3'd0);

   always_ff @(posedge clk) begin
      if (rst)            sent_cnt <= 8'd0;
      else if (word_done) sent_cnt <= sent_cnt + 8'd1;
   end
`endif

endmodule
